// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - round-robin arbiter sharing one memory port among CLIENT_CNT clients
module mem_rr_arbiter #(
  parameter  int M_WIDTH    = 8,
  parameter  int CLIENT_CNT = 2,
  localparam int IDX_W      = $clog2(CLIENT_CNT)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CLIENT_CNT-1:0]           client_requests,
  input  logic [CLIENT_CNT*M_WIDTH-1:0]   client_addrs_packed,
  input  logic [CLIENT_CNT-1:0]           client_wes,
  input  logic [2*CLIENT_CNT-1:0]         client_data_widths_packed,
  input  logic [CLIENT_CNT*M_WIDTH-1:0]   client_data_outs_packed,
  input  logic [M_WIDTH-1:0]              mem_data_in,
  input  logic                            mem_ready,
  output logic                            mem_request,
  output logic [M_WIDTH-1:0]              mem_addr,
  output logic [M_WIDTH-1:0]              mem_data_out,
  output logic [1:0]                      mem_data_width,
  output logic                            mem_we_out,
  output logic [CLIENT_CNT*M_WIDTH-1:0]   client_data_ins_packed,
  output logic [CLIENT_CNT-1:0]           client_readies,
  output logic [IDX_W-1:0]                grant_idx,
  output logic                            busy
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE} state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic                    mem_request_q, mem_request_d;
  logic                    busy_q, busy_d;
  logic [CLIENT_CNT-1:0]   readies_q, readies_d;
  logic [M_WIDTH-1:0]      data_ins_q [CLIENT_CNT];
  logic [M_WIDTH-1:0]      data_ins_d [CLIENT_CNT];

  logic [M_WIDTH-1:0]      addr_a  [CLIENT_CNT];
  logic [M_WIDTH-1:0]      dout_a  [CLIENT_CNT];
  logic [1:0]              width_a [CLIENT_CNT];

  logic [IDX_W-1:0]        winner;
  logic [IDX_W-1:0]        cand_idx;
  logic [IDX_W-1:0]        rr_wrap;
  int                      cand;

  for (genvar i = 0; i < CLIENT_CNT; i++) begin : g_unpack
    assign addr_a[i]  = client_addrs_packed[M_WIDTH*i +: M_WIDTH];
    assign dout_a[i]  = client_data_outs_packed[M_WIDTH*i +: M_WIDTH];
    assign width_a[i] = client_data_widths_packed[2*i +: 2];
    assign client_data_ins_packed[M_WIDTH*i +: M_WIDTH] = data_ins_q[i];
  end

  // Scan from rr_ptr upward (modulo CLIENT_CNT); descending loop leaves the nearest requester
  always_comb begin
    winner   = rr_ptr_q;
    cand     = 0;
    cand_idx = '0;
    for (int k = CLIENT_CNT - 1; k >= 0; k--) begin
      cand     = (int'(rr_ptr_q) + k) % CLIENT_CNT;
      cand_idx = IDX_W'(cand);
      if (client_requests[cand_idx]) begin
        winner = cand_idx;
      end
    end
  end

  // Pointer moves just past the client that finished or aborted
  always_comb begin
    rr_wrap = (grant_idx_q == IDX_W'(CLIENT_CNT - 1)) ? '0 : grant_idx_q + 1'b1;
  end

  // Next-state logic: IDLE -> ACCESS -> DONE -> IDLE, with abort from ACCESS straight to IDLE
  always_comb begin
    state_d       = state_q;
    grant_idx_d   = grant_idx_q;
    rr_ptr_d      = rr_ptr_q;
    mem_request_d = mem_request_q;
    busy_d        = busy_q;
    readies_d     = readies_q;
    data_ins_d    = data_ins_q;
    case (state_q)
      ST_IDLE: begin
        if (|client_requests) begin
          grant_idx_d   = winner;
          state_d       = ST_ACCESS;
          mem_request_d = 1'b1;
          busy_d        = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (!client_requests[grant_idx_q]) begin
          // abort beats a simultaneous mem_ready: nothing latched, no ready pulse
          state_d       = ST_IDLE;
          rr_ptr_d      = rr_wrap;
          mem_request_d = 1'b0;
          busy_d        = 1'b0;
        end else if (mem_ready) begin
          data_ins_d[grant_idx_q] = mem_data_in;
          state_d                 = ST_DONE;
          mem_request_d           = 1'b0;
          readies_d               = '0;
          readies_d[grant_idx_q]  = 1'b1;
        end
      end
      ST_DONE: begin
        if (!client_requests[grant_idx_q]) begin
          state_d   = ST_IDLE;
          rr_ptr_d  = rr_wrap;
          readies_d = '0;
          busy_d    = 1'b0;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        mem_request_d = 1'b0;
        readies_d     = '0;
        busy_d        = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      mem_request_q <= 1'b0;
      busy_q        <= 1'b0;
      readies_q     <= '0;
      for (int i = 0; i < CLIENT_CNT; i++) begin
        data_ins_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      mem_request_q <= mem_request_d;
      busy_q        <= busy_d;
      readies_q     <= readies_d;
      data_ins_q    <= data_ins_d;
    end
  end

  // Granted client's fields pass through while busy; write enable only while the request is live
  always_comb begin
    mem_addr       = busy_q ? addr_a[grant_idx_q]  : '0;
    mem_data_out   = busy_q ? dout_a[grant_idx_q]  : '0;
    mem_data_width = busy_q ? width_a[grant_idx_q] : 2'b00;
    mem_we_out     = mem_request_q & client_wes[grant_idx_q];
  end

  assign mem_request    = mem_request_q;
  assign client_readies = readies_q;
  assign grant_idx      = grant_idx_q;
  assign busy           = busy_q;

endmodule
